// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-RAM arbiter between the icache and dcache miss paths.
package mem_arbiter_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signals of the arbiter; slave is the arbiter's view, master the environment's.
interface mem_arbiter_if #(
    parameter int WORD_W = mem_arbiter_pkg::WORD_W
);
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;

    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              dwait;
    logic [WORD_W-1:0] dload;

    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic              ram_ack;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ack,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ack,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Grants the single RAM port to icache or dcache, holding the grant until ram_ack.
// Dcache wins ties unless it has already taken MAX_DSTREAK grants while icache was waiting.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WORD_W      = mem_arbiter_pkg::WORD_W,
    parameter int MAX_DSTREAK = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
);

    localparam int                SW   = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0]     SMAX = SW'(MAX_DSTREAK);

    arb_state_t    state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          d_req;

    assign d_req = bus.dREN | bus.dWEN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        unique case (state_q)
            IDLE: begin
                if (d_req && (!bus.iREN || streak_q < SMAX)) state_d = DGNT;
                else if (bus.iREN)                           state_d = IGNT;
            end
            DGNT: begin
                if (bus.ram_ack) begin
                    state_d = IDLE;
                    // Only dcache grants taken while icache waits count toward the streak.
                    if (bus.iREN) streak_d = (streak_q == SMAX) ? SMAX : streak_q + 1'b1;
                    else          streak_d = '0;
                end
            end
            IGNT: begin
                if (bus.ram_ack) begin
                    state_d  = IDLE;
                    streak_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes follow the live request of the granted side; ack is forwarded in the same cycle.
    always_comb begin
        bus.iwait    = 1'b1;
        bus.iload    = '0;
        bus.dwait    = 1'b1;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        unique case (state_q)
            IGNT: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                if (bus.ram_ack) begin
                    bus.iwait = 1'b0;
                    bus.iload = bus.ramload;
                end
            end
            DGNT: begin
                bus.ramREN   = bus.dREN;
                bus.ramWEN   = bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                if (bus.ram_ack) begin
                    bus.dwait = 1'b0;
                    bus.dload = bus.ramload;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: cache drivers, a latency-randomized RAM and a grant-order model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int MAXD = 4;

    typedef struct {
        bit    wr;
        word_t addr;
        word_t data;
    } req_t;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    mem_arbiter_if #(.WORD_W(WORD_W)) bus ();

    mem_arbiter #(.WORD_W(WORD_W), .MAX_DSTREAK(MAXD)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;

    int   n_tests = 0;
    int   n_fail  = 0;
    req_t iq[$];
    req_t dq[$];
    byte  grants[$];
    int   i_done   = 0;
    int   d_done   = 0;
    int   last_len = 0;
    int   fix_lat  = 0;
    bit   spur     = 1'b0;

    function automatic word_t rdata(word_t a);
        return (a == 32'h40) ? 32'hDEAD_BEEF : ((a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_pattern(string name, int from, string exp);
        string act;
        act = exp;
        for (int j = 0; j < exp.len(); j++)
            act.putc(j, (from + j < grants.size()) ? grants[from + j] : 8'h2D);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %s expected %s", name, act, exp);
        end
    endtask

    task automatic i_access(word_t a);
        int   t;
        req_t r;
        t = 0;
        r.wr = 1'b0; r.addr = a; r.data = rdata(a);
        iq.push_back(r);
        bus.iREN  = 1'b1;
        bus.iaddr = a;
        do begin @(negedge CLK); t++; end while (bus.iwait && t < 200);
        n_tests++;
        if (t >= 200) begin
            n_fail++;
            $display("FAIL i_timeout: waited %0d cycles, required completion", t);
        end
        @(posedge CLK); #1;
    endtask

    task automatic d_access(bit wr, word_t a, word_t s);
        int   t;
        req_t r;
        t = 0;
        r.wr = wr; r.addr = a; r.data = s;
        dq.push_back(r);
        bus.dREN   = !wr;
        bus.dWEN   = wr;
        bus.daddr  = a;
        bus.dstore = s;
        do begin @(negedge CLK); t++; end while (bus.dwait && t < 200);
        n_tests++;
        if (t >= 200) begin
            n_fail++;
            $display("FAIL d_timeout: waited %0d cycles, required completion", t);
        end
        @(posedge CLK); #1;
    endtask

    // RAM model: acks the lat-th cycle of a strobe; read data is a fixed function of the address.
    initial begin : ram_model
        int k;
        int lat;
        k = 0; lat = 1;
        bus.ram_ack = 1'b0;
        bus.ramload = '0;
        forever begin
            @(posedge CLK); #1;
            bus.ram_ack = spur;
            bus.ramload = spur ? 32'hFFFF_FFFF : 32'h0;
            if (bus.ramREN || bus.ramWEN) begin
                if (k == 0) lat = (fix_lat != 0) ? fix_lat : int'($urandom_range(1, 4));
                k++;
                if (k >= lat) begin
                    bus.ram_ack = 1'b1;
                    bus.ramload = bus.ramREN ? rdata(bus.ramaddr) : 32'h0;
                    k = 0;
                end
            end else begin
                k = 0;
            end
        end
    end

    // Monitor: predicts each grant from who was waiting and the dcache streak, checks strobes and responses.
    initial begin : monitor
        bit   in_acc, was_done, pi, pd, stb, ic, dc;
        byte  g;
        int   streak, acc_len;
        req_t r;
        in_acc = 0; was_done = 0; pi = 0; pd = 0; g = "N"; streak = 0; acc_len = 0;
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                in_acc = 0; was_done = 0; pi = 0; pd = 0; streak = 0;
                continue;
            end
            stb = bus.ramREN || bus.ramWEN;
            if (was_done) chk("arb_cycle_strobe", 32'(stb), 0);
            if (in_acc && !stb) begin
                chk("strobe_held", 32'(stb), 1);
                in_acc = 0;
            end
            if (stb && !in_acc && !was_done) begin
                in_acc  = 1;
                acc_len = 0;
                g = (pd && (!pi || streak < MAXD)) ? "D" : (pi ? "I" : "N");
                grants.push_back(g);
                chk("grant_has_requester", 32'(g == "N"), 0);
            end
            if (in_acc) begin
                acc_len++;
                if (g == "I" && iq.size() > 0) begin
                    chk("i_strobe", {30'd0, bus.ramWEN, bus.ramREN}, 32'd1);
                    chk("i_ramaddr", bus.ramaddr, iq[0].addr);
                    chk("i_ramstore", bus.ramstore, 0);
                    chk("i_req_held", 32'(bus.iREN), 1);
                end else if (g == "D" && dq.size() > 0) begin
                    chk("d_strobe", {30'd0, bus.ramWEN, bus.ramREN}, dq[0].wr ? 32'd2 : 32'd1);
                    chk("d_ramaddr", bus.ramaddr, dq[0].addr);
                    chk("d_ramstore", bus.ramstore, dq[0].data);
                    chk("d_req_held", 32'(bus.dREN | bus.dWEN), 1);
                end
            end
            ic = in_acc && g == "I" && bus.ram_ack;
            dc = in_acc && g == "D" && bus.ram_ack;
            chk("iwait", 32'(bus.iwait), 32'(!ic));
            chk("dwait", 32'(bus.dwait), 32'(!dc));
            if (!ic) chk("iload_idle", bus.iload, 0);
            if (!dc) chk("dload_idle", bus.dload, 0);
            was_done = 0;
            if (ic) begin
                chk("i_pending", 32'(iq.size() > 0), 1);
                if (iq.size() > 0) begin
                    r = iq.pop_front();
                    chk("iload", bus.iload, r.data);
                end
                streak = 0;
                i_done++;
            end
            if (dc) begin
                chk("d_pending", 32'(dq.size() > 0), 1);
                if (dq.size() > 0) begin
                    r = dq.pop_front();
                    chk("dload", bus.dload, r.wr ? 32'h0 : rdata(r.addr));
                end
                streak = bus.iREN ? ((streak + 1 > MAXD) ? MAXD : streak + 1) : 0;
                d_done++;
            end
            if (ic || dc) begin
                in_acc   = 0;
                was_done = 1;
                last_len = acc_len;
            end
            pi = bus.iREN;
            pd = bus.dREN | bus.dWEN;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        int d0;
        int t;
        bus.iREN = 0; bus.iaddr = '0;
        bus.dREN = 0; bus.dWEN = 0; bus.daddr = '0; bus.dstore = '0;

        // Reset values
        repeat (2) @(negedge CLK);
        chk("rst_iwait", 32'(bus.iwait), 1);
        chk("rst_dwait", 32'(bus.dwait), 1);
        chk("rst_ramREN", 32'(bus.ramREN), 0);
        chk("rst_ramWEN", 32'(bus.ramWEN), 0);
        chk("rst_ramaddr", bus.ramaddr, 0);
        chk("rst_ramstore", bus.ramstore, 0);
        chk("rst_iload", bus.iload, 0);
        chk("rst_dload", bus.dload, 0);
        @(posedge CLK); #1;
        nRST = 1'b1;

        // Icache read, latency 3
        fix_lat = 3;
        i_access(32'h0000_0040);
        bus.iREN = 0;
        chk("i_lat3_cycles", last_len, 3);

        // Dcache write, latency 1
        fix_lat = 1;
        d_access(1'b1, 32'h100, 32'h1234_5678);
        bus.dWEN = 0;
        chk("d_lat1_cycles", last_len, 1);

        // Both held continuously
        fix_lat = 2;
        base = grants.size();
        fork
            begin i_access(32'h400); i_access(32'h404); bus.iREN = 0; end
            begin
                for (int n = 0; n < 8; n++) d_access(1'b0, 32'h800 + 32'(4 * n), 32'(n));
                bus.dREN = 0;
            end
        join
        chk_pattern("both_held_order", base, "DDDDIDDDDI");

        // Dcache streams alone; icache joins after two completions
        fix_lat = 1;
        d0 = d_done;
        fork
            begin
                for (int n = 0; n < 8; n++) d_access(n[0], 32'hA00 + 32'(4 * n), 32'hC0DE_0000 + 32'(n));
                bus.dREN = 0; bus.dWEN = 0;
            end
            begin
                t = 0;
                do begin @(negedge CLK); #1; t++; end while (d_done < d0 + 2 && t < 200);
                @(posedge CLK); #1;
                base = grants.size();
                i_access(32'h500);
                bus.iREN = 0;
            end
        join
        chk_pattern("iren_late_order", base, "DDDDI");

        // Reset in the middle of a dcache grant
        fix_lat = 8;
        d0 = d_done;
        fork
            begin d_access(1'b0, 32'h200, 32'h77); bus.dREN = 0; end
        join_none
        repeat (3) @(posedge CLK);
        #3 nRST = 1'b0;
        #1;
        chk("rst_mid_ramREN", 32'(bus.ramREN), 0);
        chk("rst_mid_ramWEN", 32'(bus.ramWEN), 0);
        chk("rst_mid_dwait", 32'(bus.dwait), 1);
        chk("rst_mid_ramaddr", bus.ramaddr, 0);
        fix_lat = 2;
        @(posedge CLK); #2;
        nRST = 1'b1;
        t = 0;
        do begin @(negedge CLK); #1; t++; end while (d_done == d0 && t < 200);
        chk("rst_regrant_done", d_done, d0 + 1);
        @(posedge CLK); #2;

        // Spurious ack while idle
        spur = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("spur_iwait", 32'(bus.iwait), 1);
        chk("spur_dwait", 32'(bus.dwait), 1);
        chk("spur_ramREN", 32'(bus.ramREN | bus.ramWEN), 0);
        @(posedge CLK); #1;
        spur = 1'b0;
        @(posedge CLK); #1;

        // Randomized traffic with random latency
        fix_lat = 0;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    int gap;
                    gap = int'($urandom_range(0, 3));
                    if (gap != 0) begin
                        bus.iREN = 0;
                        repeat (gap) begin @(posedge CLK); #1; end
                    end
                    i_access(word_t'($urandom) & ~32'h3);
                end
                bus.iREN = 0;
            end
            begin
                for (int n = 0; n < 80; n++) begin
                    int gap;
                    gap = int'($urandom_range(0, 2));
                    if (gap != 0) begin
                        bus.dREN = 0; bus.dWEN = 0;
                        repeat (gap) begin @(posedge CLK); #1; end
                    end
                    d_access(1'($urandom_range(0, 1)), word_t'($urandom) & ~32'h3, word_t'($urandom));
                end
                bus.dREN = 0; bus.dWEN = 0;
            end
        join

        repeat (3) @(posedge CLK);
        chk("iq_drained", iq.size(), 0);
        chk("dq_drained", dq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
